calc_engine: RTL and testbench

- Parametrised successor of the 4-bit repetitive-subtraction divider FSM.
- WIDTH-bit sequential arithmetic engine with four modes: add, subtract, shift-add multiply and restoring divide.
- Uses the same Start/Ack handshake and Qi/Qc/Qd state outputs, so it drops into the board top: switches feed Xin/Yin, the SSD scanner shows ResHi/ResLo, LEDs show states and Done.
- Multiply and divide take one iteration per operand bit, not one per quotient unit.

---
 rtl/calc_pkg.sv | 15 +
 rtl/calc_iter_unit.sv | 40 ++++
 rtl/calc_engine.sv | 158 +++++++++++++++
 tb/tb_calc_engine.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared opcodes and one-hot state encoding for the sequential arithmetic engine.
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    QI = 3'b001,
    QC = 3'b010,
    QD = 3'b100
  } state_e;

endpackage

// File: rtl/calc_iter_unit.sv
// One iteration of the shift-add multiplier or the restoring divider.
// acc is the upper half (accumulator / remainder), lo the lower half
// (multiplier / quotient) of the working pair.
module calc_iter_unit
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] acc_nxt_c,
  output logic [WIDTH-1:0] lo_nxt_c
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;

  // Mul: conditional add then right shift; div: left shift then compare-subtract.
  always_comb begin
    mul_sum   = {1'b0, acc} + (lo[0] ? {1'b0, y} : (WIDTH+1)'(0));
    rem_sh    = {acc, lo[WIDTH-1]};
    // The remainder before the shift is < y, so the true difference fits WIDTH bits.
    rem_sub   = rem_sh[WIDTH-1:0] - y;
    acc_nxt_c = mul_sum[WIDTH:1];
    lo_nxt_c  = {mul_sum[0], lo[WIDTH-1:1]};
    if (op == OP_DIV) begin
      if (rem_sh >= {1'b0, y}) begin
        acc_nxt_c = rem_sub;
        lo_nxt_c  = {lo[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt_c = rem_sh[WIDTH-1:0];
        lo_nxt_c  = {lo[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/calc_engine.sv
// WIDTH-bit sequential add/sub/mul/div engine with Start/Ack handshake and
// one-hot state outputs. Results only change on the QC->QD transition.
module calc_engine
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNTW  = $clog2(WIDTH + 1)
) (
  input  logic             board_clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic             Ack,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] Xin,
  input  logic [WIDTH-1:0] Yin,
  output logic [WIDTH-1:0] ResLo,
  output logic [WIDTH-1:0] ResHi,
  output logic             Err,
  output logic             Done,
  output logic             Qi,
  output logic             Qc,
  output logic             Qd
);

  state_e           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic             err_q, err_d;

  logic [WIDTH:0]   add_c;
  logic [WIDTH:0]   sub_c;
  logic [WIDTH-1:0] acc_nxt_c;
  logic [WIDTH-1:0] lo_nxt_c;

  calc_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .op        (op_q),
    .acc       (acc_q),
    .lo        (lo_q),
    .y         (y_q),
    .acc_nxt_c (acc_nxt_c),
    .lo_nxt_c  (lo_nxt_c)
  );

  // Single-cycle add/sub on the latched operands.
  always_comb begin
    add_c = {1'b0, x_q} + {1'b0, y_q};
    sub_c = {1'b0, x_q} - {1'b0, y_q};
  end

  // Next-state, working-register and result-register logic.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    x_d      = x_q;
    y_d      = y_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    err_d    = err_q;
    case (state_q)
      QI: begin
        if (Start) begin
          op_d    = Op;
          x_d     = Xin;
          y_d     = Yin;
          acc_d   = '0;
          lo_d    = Xin;
          cnt_d   = '0;
          state_d = QC;
        end
      end
      QC: begin
        case (op_q)
          OP_ADD: begin
            res_lo_d = add_c[WIDTH-1:0];
            res_hi_d = WIDTH'(add_c[WIDTH]);
            err_d    = 1'b0;
            state_d  = QD;
          end
          OP_SUB: begin
            res_lo_d = sub_c[WIDTH-1:0];
            res_hi_d = '0;
            err_d    = sub_c[WIDTH];
            state_d  = QD;
          end
          default: begin
            if (op_q == OP_DIV && y_q == '0) begin
              res_lo_d = '1;
              res_hi_d = x_q;
              err_d    = 1'b1;
              state_d  = QD;
            end else begin
              acc_d = acc_nxt_c;
              lo_d  = lo_nxt_c;
              cnt_d = cnt_q + CNTW'(1);
              if (cnt_q == CNTW'(WIDTH - 1)) begin
                res_lo_d = lo_nxt_c;
                res_hi_d = acc_nxt_c;
                err_d    = 1'b0;
                state_d  = QD;
              end
            end
          end
        endcase
      end
      QD: begin
        if (Ack) begin
          state_d = QI;
        end
      end
      default: state_d = QI;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= QI;
      op_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      x_q      <= x_d;
      y_q      <= y_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      err_q    <= err_d;
    end
  end

  assign ResLo = res_lo_q;
  assign ResHi = res_hi_q;
  assign Err   = err_q;
  assign Qi    = state_q[0];
  assign Qc    = state_q[1];
  assign Qd    = state_q[2];
  assign Done  = state_q[2];

endmodule

// File: tb/tb_calc_engine.sv
// Scoreboard bench for calc_engine (WIDTH = 8) with directed vectors.
module tb_calc_engine;
  import calc_pkg::*;

  localparam int unsigned W = 8;

  logic         board_clk = 1'b0;
  logic         Reset;
  logic         Start;
  logic         Ack;
  logic [1:0]   Op;
  logic [W-1:0] Xin;
  logic [W-1:0] Yin;
  logic [W-1:0] ResLo;
  logic [W-1:0] ResHi;
  logic         Err;
  logic         Done;
  logic         Qi;
  logic         Qc;
  logic         Qd;

  typedef struct packed {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  logic done_prev = 1'b0;
  int   total  = 0;
  int   passed = 0;

  calc_engine #(.WIDTH(W)) dut (
    .board_clk (board_clk),
    .Reset     (Reset),
    .Start     (Start),
    .Ack       (Ack),
    .Op        (Op),
    .Xin       (Xin),
    .Yin       (Yin),
    .ResLo     (ResLo),
    .ResHi     (ResHi),
    .Err       (Err),
    .Done      (Done),
    .Qi        (Qi),
    .Qc        (Qc),
    .Qd        (Qd)
  );

  always #5 board_clk = ~board_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Monitor: every rising Done pops one expected result and compares it.
  always @(negedge board_clk) begin
    if (Done === 1'b1 && done_prev === 1'b0) begin
      check("done_has_expectation", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("mon_res_lo", 32'(ResLo), 32'(mon_e.lo));
        check("mon_res_hi", 32'(ResHi), 32'(mon_e.hi));
        check("mon_err",    32'(Err),   32'(mon_e.err));
      end
    end
    done_prev = Done;
  end

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int exp_qc, input logic [W-1:0] elo, input logic [W-1:0] ehi,
                        input logic eerr, input string tag);
    int n;
    int changes;
    logic [W-1:0] lo0;
    exp_t e;
    e.lo = elo; e.hi = ehi; e.err = eerr;
    exp_q.push_back(e);
    @(negedge board_clk);
    Op = op; Xin = x; Yin = y; Start = 1'b1;
    @(negedge board_clk);
    Start = 1'b0;
    n = 0;
    changes = 0;
    lo0 = ResLo;
    while (Qc === 1'b1 && n < 64) begin
      n++;
      if (ResLo !== lo0) changes++;
      Xin = ~Xin; Yin = ~Yin; Op = ~Op;
      @(negedge board_clk);
    end
    check({tag, "_qc_cycles"}, 32'(n), 32'(exp_qc));
    check({tag, "_no_partial"}, 32'(changes), 32'd0);
    check({tag, "_done"}, 32'(Done), 32'd1);
    Ack = 1'b1;
    @(negedge board_clk);
    Ack = 1'b0;
    check({tag, "_qi_after_ack"}, 32'(Qi), 32'd1);
    check({tag, "_lo_held"}, 32'(ResLo), 32'(elo));
    check({tag, "_hi_held"}, 32'(ResHi), 32'(ehi));
  endtask

  initial begin
    exp_t e;
    int n;
    Reset = 1'b1; Start = 1'b0; Ack = 1'b0; Op = 2'b00; Xin = '0; Yin = '0;
    repeat (2) @(negedge board_clk);
    check("rst_qi",     32'(Qi),    32'd1);
    check("rst_qc",     32'(Qc),    32'd0);
    check("rst_qd",     32'(Qd),    32'd0);
    check("rst_res_lo", 32'(ResLo), 32'd0);
    check("rst_res_hi", 32'(ResHi), 32'd0);
    check("rst_err",    32'(Err),   32'd0);
    Reset = 1'b0;

    run_op(OP_DIV, 8'd200, 8'd7,   8, 8'd28,  8'd4,  1'b0, "div200_7");
    run_op(OP_MUL, 8'd255, 8'd255, 8, 8'h01,  8'hFE, 1'b0, "mul255_255");
    run_op(OP_SUB, 8'd5,   8'd9,   1, 8'hFC,  8'h00, 1'b1, "sub5_9");
    run_op(OP_ADD, 8'hF0,  8'h20,  1, 8'h10,  8'h01, 1'b0, "addF0_20");
    run_op(OP_MUL, 8'd13,  8'd11,  8, 8'h8F,  8'h00, 1'b0, "mul13_11");
    run_op(OP_DIV, 8'd255, 8'd16,  8, 8'd15,  8'd15, 1'b0, "div255_16");
    run_op(OP_DIV, 8'd5,   8'd9,   8, 8'd0,   8'd5,  1'b0, "div5_9");
    run_op(OP_SUB, 8'd9,   8'd5,   1, 8'd4,   8'd0,  1'b0, "sub9_5");

    // Divide by zero with Start and Ack held: auto-restart every 3 cycles.
    e.lo = 8'hFF; e.hi = 8'h5A; e.err = 1'b1;
    for (int k = 0; k < 3; k++) exp_q.push_back(e);
    @(negedge board_clk);
    Op = OP_DIV; Xin = 8'h5A; Yin = 8'h00; Start = 1'b1; Ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin
        @(negedge board_clk);
        n++;
      end while (Done !== 1'b1 && n < 20);
      check("div0_done_gap", 32'(n), (k == 0) ? 32'd2 : 32'd3);
    end
    Start = 1'b0;
    @(negedge board_clk);
    Ack = 1'b0;
    check("div0_qi_after", 32'(Qi),    32'd1);
    check("div0_lo_held",  32'(ResLo), 32'hFF);

    // Reset in the 4th QC cycle of a multiply.
    @(negedge board_clk);
    Op = OP_MUL; Xin = 8'd255; Yin = 8'd255; Start = 1'b1;
    @(negedge board_clk);
    Start = 1'b0;
    repeat (3) @(negedge board_clk);
    check("midrst_in_qc", 32'(Qc), 32'd1);
    Reset = 1'b1;
    #1;
    check("midrst_qi",     32'(Qi),    32'd1);
    check("midrst_qc",     32'(Qc),    32'd0);
    check("midrst_res_lo", 32'(ResLo), 32'd0);
    check("midrst_res_hi", 32'(ResHi), 32'd0);
    check("midrst_err",    32'(Err),   32'd0);
    @(negedge board_clk);
    Reset = 1'b0;
    repeat (2) @(negedge board_clk);
    check("midrst_no_done", 32'(Done), 32'd0);

    run_op(OP_DIV, 8'd9, 8'd3, 8, 8'd3, 8'd0, 1'b0, "div9_3");

    repeat (2) @(negedge board_clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
